// File: rtl/zbt_pkg.sv
// Shared constants for the ZBT pixel packer: word width and default geometry.
// Parity over spare bits is compiled in only when ZBT_PACKER_PARITY_EN is defined.
package zbt_pkg;

  localparam int ZBT_WORD_W = 36;

  localparam int DEF_PIX_W        = 8;
  localparam int DEF_PIX_PER_WORD = 4;
  localparam int DEF_ADDR_W       = 19;
  localparam int DEF_BASE_ADDR    = 0;
  localparam int DEF_FRAME_WORDS  = 19200;

endpackage

// File: rtl/zbt_addr_gen.sv
// Frame buffer address allocator: wrapping word counter plus frame_done pulse.
// Addresses are handed out at load time; frame_done follows the last word's consume.
module zbt_addr_gen
  import zbt_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart_i,
  input  logic              advance_i,
  input  logic              consume_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              frame_done_o
);

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d, cur;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              is_last;

  assign cur          = restart_i ? BASE : cnt_q;
  assign is_last      = (cur == LAST);
  assign addr_o       = cur;
  assign frame_done_o = done_q;

  always_comb begin
    cnt_d  = cur;
    last_d = last_q;
    done_d = consume_i && last_q;
    if (consume_i) begin
      last_d = 1'b0;
    end
    if (advance_i) begin
      cnt_d  = is_last ? BASE : cur + 1'b1;
      // last_q tracks whether the word now in the output register ends a frame
      last_d = is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= BASE;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/zbt_pixel_packer.sv
// Packs PIX_PER_WORD pixels into 36-bit ZBT write words with flush and frame restart.
// Define ZBT_PACKER_PARITY_EN to place per-pixel even parity in the spare bits.
module zbt_pixel_packer
  import zbt_pkg::*;
#(
  parameter int PIX_W        = DEF_PIX_W,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BASE_ADDR    = DEF_BASE_ADDR,
  parameter int FRAME_WORDS  = DEF_FRAME_WORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIX_W-1:0]      pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic                  frame_start,
  input  logic                  flush,
  output logic [ZBT_WORD_W-1:0] zbt_data,
  output logic [ADDR_W-1:0]     zbt_addr,
  output logic                  zbt_we,
  input  logic                  zbt_ready,
  output logic                  frame_done
);

  localparam int PACK_W  = PIX_W * PIX_PER_WORD;
  localparam int SPARE_W = ZBT_WORD_W - PACK_W;
  localparam int CNT_W   = $clog2(PIX_PER_WORD + 1);
  localparam int NPAR    =
    (PIX_PER_WORD < SPARE_W) ? PIX_PER_WORD : SPARE_W;
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(PIX_PER_WORD);
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  logic [PACK_W-1:0]     acc_q, acc_d, acc_new;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_base, cnt_new;
  logic                  pend_q, pend_d;
  logic [ZBT_WORD_W-1:0] data_q, data_d, word;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     gen_addr;
  logic                  we_q, we_d;
  logic                  out_free, take, consume;
  logic                  flush_req, load;

  assign out_free    = !we_q || zbt_ready;
  assign pixel_ready = reset_n && out_free && !pend_q;
  assign take        = pixel_valid && pixel_ready;
  assign consume     = we_q && zbt_ready;

  assign zbt_data = data_q;
  assign zbt_addr = addr_q;
  assign zbt_we   = we_q;

  // frame_start wipes the partial word before this cycle's pixel lands
  always_comb begin
    cnt_base = frame_start ? '0 : cnt_q;
    acc_new  = frame_start ? '0 : acc_q;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (take && cnt_base == CNT_W'(k)) begin
        acc_new[k*PIX_W +: PIX_W] = pixel_data;
      end
    end
    cnt_new = cnt_base + CNT_W'(take);
  end

  always_comb begin
    word = '0;
    word[PACK_W-1:0] = acc_new;
`ifdef ZBT_PACKER_PARITY_EN
    for (int k = 0; k < NPAR; k++) begin
      word[PACK_W+k] = ^acc_new[k*PIX_W +: PIX_W];
    end
`endif
  end

  always_comb begin
    flush_req = !frame_start && (flush || pend_q);
    load      = (cnt_new == FULL) ||
                (flush_req && out_free && cnt_new != '0);
    acc_d  = acc_new;
    cnt_d  = cnt_new;
    pend_d = flush_req && cnt_new != '0;
    data_d = data_q;
    addr_d = addr_q;
    we_d   = we_q && !zbt_ready;
    if (load) begin
      acc_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
      data_d = word;
      addr_d = gen_addr;
      we_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      data_q <= '0;
      addr_q <= BASE;
      we_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      data_q <= data_d;
      addr_q <= addr_d;
      we_q   <= we_d;
    end
  end

  zbt_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart_i    (frame_start),
    .advance_i    (load),
    .consume_i    (consume),
    .addr_o       (gen_addr),
    .frame_done_o (frame_done)
  );

endmodule

// File: tb/tb_zbt_pixel_packer.sv
// Scoreboard bench for zbt_pixel_packer with a 3-word frame.
// Parity expectations follow ZBT_PACKER_PARITY_EN when it is defined.
module tb_zbt_pixel_packer;

  localparam int AW = 19;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [35:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    pixel_data = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic          frame_start = 1'b0;
  logic          flush = 1'b0;
  logic [35:0]   zbt_data;
  logic [AW-1:0] zbt_addr;
  logic          zbt_we;
  logic          zbt_ready = 1'b0;
  logic          frame_done;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  fd_cnt = 0;

  logic [31:0]   m_acc;
  int            m_cnt;
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  zbt_pixel_packer #(
    .PIX_W        (8),
    .PIX_PER_WORD (4),
    .ADDR_W       (AW),
    .BASE_ADDR    (0),
    .FRAME_WORDS  (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .frame_start (frame_start),
    .flush       (flush),
    .zbt_data    (zbt_data),
    .zbt_addr    (zbt_addr),
    .zbt_we      (zbt_we),
    .zbt_ready   (zbt_ready),
    .frame_done  (frame_done)
  );

  always @(negedge clk) begin
    if (reset_n && zbt_we && zbt_ready) begin
      obs_q.push_back('{a: zbt_addr, d: zbt_data});
    end
    if (frame_done) fd_cnt++;
  end

  function automatic logic [35:0] mk_word(input logic [31:0] acc);
    logic [35:0] w;
    w = {4'b0000, acc};
`ifdef ZBT_PACKER_PARITY_EN
    for (int k = 0; k < 4; k++) w[32+k] = ^acc[8*k +: 8];
`endif
    return w;
  endfunction

  task automatic m_reset();
    m_acc = '0;
    m_cnt = 0;
    m_addr = '0;
  endtask

  task automatic m_emit();
    exp_q.push_back('{a: m_addr, d: mk_word(m_acc)});
    m_addr = (m_addr == 19'd2) ? 19'd0 : m_addr + 1'b1;
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic m_pix(input logic [7:0] p);
    m_acc[8*m_cnt +: 8] = p;
    m_cnt++;
    if (m_cnt == 4) m_emit();
  endtask

  task automatic send_pix(input logic [7:0] p, input bit fs,
                          input bit fl, input bit mdl,
                          output int cyc);
    bit acc;
    int t;
    pixel_data = p;
    pixel_valid = 1'b1;
    frame_start = fs;
    flush = fl;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = pixel_ready;
      @(posedge clk);
      #1;
      t++;
      frame_start = 1'b0;
      flush = 1'b0;
    end
    pixel_valid = 1'b0;
    cyc = t;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_pix_timeout ready=0 want 1");
    end else if (mdl) begin
      if (fs) m_reset();
      m_pix(p);
      if (fl && m_cnt > 0) m_emit();
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (m_cnt > 0) m_emit();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    zbt_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (zbt_we !== 1'b0) begin
      n_err++; $display("FAIL rst_we got %b want 0", zbt_we);
    end
    n_cmp++;
    if (zbt_data !== 36'h0) begin
      n_err++; $display("FAIL rst_data got %h want 0", zbt_data);
    end
    n_cmp++;
    if (zbt_addr !== 19'd0) begin
      n_err++; $display("FAIL rst_addr got %h want 0", zbt_addr);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL rst_done got %b want 0", frame_done);
    end
    n_cmp++;
    if (pixel_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_ready got %b want 0", pixel_ready);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    n_cmp++;
    if (pixel_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_ready got %b want 1", pixel_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int c, tot;
    wr_t e, o;
    zbt_ready = 1'b1;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_pix(8'((i + 1) * 17), 1'b0, 1'b0, 1'b1, c);
      tot += c;
    end
    n_cmp++;
    if (tot !== 8) begin
      n_err++; $display("FAIL basic_rate got %0d cycles want 8", tot);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_err++; $display("FAIL basic_count got %0d want 2", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {19'd0, 36'h044332211}) begin
        n_err++;
        $display("FAIL basic_w0 got %h@%h want 044332211@0",
                 obs_q[0].d, obs_q[0].a);
      end
      n_cmp++;
      if (obs_q[1] !== {19'd1, 36'h088776655}) begin
        n_err++;
        $display("FAIL basic_w1 got %h@%h want 088776655@1",
                 obs_q[1].d, obs_q[1].a);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stall();
    int c, n0, fd0;
    wr_t e, o;
    zbt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_pix(8'(i), 1'b0, 1'b0, 1'b1, c);
    end
    n0 = obs_q.size();
    fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (zbt_we !== 1'b1 || zbt_data !== 36'h004030201 ||
          zbt_addr !== 19'd2 || pixel_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold got we=%b %h@%h rdy=%b want 1 004030201@2 0",
                 zbt_we, zbt_data, zbt_addr, pixel_ready);
      end
    end
    @(posedge clk);
    #1;
    zbt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== n0 + 1) begin
      n_err++;
      $display("FAIL stall_once got %0d want %0d", obs_q.size(), n0 + 1);
    end
    n_cmp++;
    if (fd_cnt !== fd0 + 1) begin
      n_err++;
      $display("FAIL stall_done got %0d want %0d", fd_cnt - fd0, 1);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flush();
    int c, n0;
    wr_t e, o;
    zbt_ready = 1'b1;
    send_pix(8'hAA, 1'b0, 1'b0, 1'b1, c);
    send_pix(8'hBB, 1'b0, 1'b0, 1'b1, c);
    pulse_flush();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_err++; $display("FAIL flush_count got %0d want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {19'd0, 36'h00000BBAA}) begin
        n_err++;
        $display("FAIL flush_word got %h@%h want 00000bbaa@0",
                 obs_q[0].d, obs_q[0].a);
      end
    end
    n0 = obs_q.size();
    pulse_flush();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== n0 || zbt_we !== 1'b0) begin
      n_err++;
      $display("FAIL flush_noop got %0d we=%b want %0d we=0",
               obs_q.size(), zbt_we, n0);
    end
    send_pix(8'h12, 1'b0, 1'b0, 1'b1, c);
    send_pix(8'h34, 1'b0, 1'b1, 1'b1, c);
    for (int i = 1; i <= 3; i++) begin
      send_pix(8'(i + 8'h40), 1'b0, 1'b0, 1'b1, c);
    end
    send_pix(8'h44, 1'b0, 1'b1, 1'b1, c);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL flush_sbcount got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL flush_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_wrap();
    int c, fd0;
    wr_t e, o;
    zbt_ready = 1'b1;
    pulse_fs();
    fd0 = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      send_pix(8'(8'hC0 + i), 1'b0, 1'b0, 1'b1, c);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== 4) begin
      n_err++; $display("FAIL wrap_count got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_q[i].a !== AW'(i % 3)) begin
          n_err++;
          $display("FAIL wrap_addr%0d got %0d want %0d",
                   i, obs_q[i].a, i % 3);
        end
      end
    end
    n_cmp++;
    if (fd_cnt !== fd0 + 1) begin
      n_err++;
      $display("FAIL wrap_done got %0d pulses want 1", fd_cnt - fd0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_restart();
    int c, n0;
    wr_t e, o;
    zbt_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send_pix(8'(8'hE0 + i), 1'b0, 1'b0, 1'b1, c);
    end
    send_pix(8'h01, 1'b1, 1'b0, 1'b1, c);
    for (int i = 2; i <= 4; i++) begin
      send_pix(8'(i), 1'b0, 1'b0, 1'b1, c);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_err++; $display("FAIL fs_count got %0d want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {19'd0, 36'h004030201}) begin
        n_err++;
        $display("FAIL fs_word got %h@%h want 004030201@0",
                 obs_q[0].d, obs_q[0].a);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL fs_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
    zbt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_pix(8'(8'hF0 + i), 1'b0, 1'b0, 1'b0, c);
    end
    n0 = obs_q.size();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (zbt_we !== 1'b0 || zbt_addr !== 19'd0) begin
      n_err++;
      $display("FAIL midrst got we=%b addr=%h want we=0 addr=0",
               zbt_we, zbt_addr);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    zbt_ready = 1'b1;
    m_reset();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== n0) begin
      n_err++;
      $display("FAIL midrst_drop got %0d writes want %0d", obs_q.size(), n0);
    end
    obs_q.delete();
  endtask

  task automatic test_parity();
    int c;
    logic [7:0] px [4];
    logic [3:0] want_sp;
    wr_t e, o;
    px[0] = 8'h01; px[1] = 8'h03; px[2] = 8'h07; px[3] = 8'h00;
`ifdef ZBT_PACKER_PARITY_EN
    want_sp = 4'b0101;
`else
    want_sp = 4'b0000;
`endif
    zbt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pix(px[i], 1'b0, 1'b0, 1'b1, c);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_err++; $display("FAIL par_count got %0d want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0].d[35:32] !== want_sp ||
          obs_q[0].d[31:0] !== 32'h00070301) begin
        n_err++;
        $display("FAIL par_word got %h want %h_00070301",
                 obs_q[0].d, want_sp);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL par_sb got %h@%h want %h@%h", o.d, o.a, e.d, e.a);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_wrap();
    test_restart();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zbt_pixel_packer.md
ZBT_PIXEL_PACKER -- requirements
Module: zbt_pixel_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 8: bits per input pixel.
REQ-002 SHALL have parameter PIX_PER_WORD, default 4: pixels packed per ZBT word; PIX_W*PIX_PER_WORD <= 36.
REQ-003 SHALL have parameter ADDR_W, default 19: ZBT address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0: first word address of the frame buffer.
REQ-005 SHALL have parameter FRAME_WORDS, default 19200: words per frame, >= 1.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port pixel_data, input, PIX_W: input pixel.
REQ-009 SHALL have port pixel_valid, input, 1: pixel_data is valid this cycle.
REQ-010 SHALL have port pixel_ready, output, 1: the packer accepts a pixel this cycle.
REQ-011 SHALL have port frame_start, input, 1: single-cycle pulse that restarts the frame.
REQ-012 SHALL have port flush, input, 1: single-cycle pulse that emits a partial word.
REQ-013 SHALL have port zbt_data, output, 36: packed word.
REQ-014 SHALL have port zbt_addr, output, ADDR_W: write address for zbt_data.
REQ-015 SHALL have port zbt_we, output, 1: zbt_data/zbt_addr are valid (write request).
REQ-016 SHALL have port zbt_ready, input, 1: the ZBT side accepts the request this cycle.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse when the last word of a frame is accepted.

Function
REQ-018 SHALL accept a pixel when pixel_valid && pixel_ready; pixel_ready = !zbt_we || zbt_ready, combinationally.
REQ-019 SHALL place pixel k of a word (k = 0 first received) at bits [(k+1)*PIX_W-1 : k*PIX_W].
REQ-020 SHALL clear the word's bits above PIX_W*PIX_PER_WORD to 0 (see REQ-034 for the exception).
REQ-021 SHALL maintain fill count 0..PIX_PER_WORD-1; the accept of pixel PIX_PER_WORD-1 loads the output register, sets zbt_we the next cycle (latency 1), and returns the count to 0.
REQ-022 SHALL hold zbt_data/zbt_addr/zbt_we stable while zbt_we && !zbt_ready; a word is consumed on the cycle zbt_we && zbt_ready.
REQ-023 SHALL sustain one pixel per cycle, including back-to-back words when zbt_ready stays high.
REQ-024 SHALL on flush with count > 0 emit the partial word with unfilled pixel slots zero; with count = 0, flush is a no-op.
REQ-025 SHALL on flush coincident with an accepted pixel include that pixel, then emit (if it completes a word, emit exactly one word).
REQ-026 SHALL hold flush pending while the output register is occupied and emit as soon as it frees; pixel_ready is low while a flush is pending.
REQ-027 SHALL increment the address by 1 per consumed word, starting at BASE_ADDR; after BASE_ADDR+FRAME_WORDS-1, it wraps to BASE_ADDR and pulses frame_done.
REQ-028 SHALL on frame_start discard the partial word and pending flush, set count 0 and next address BASE_ADDR; a word already in the output register completes unchanged.
REQ-029 SHALL give frame_start priority over pixel and flush in the same cycle (pixel is accepted into the new frame as slot 0).

Reset
REQ-030 SHALL on reset_n low at a clock edge set zbt_we=0, zbt_data=0, zbt_addr=BASE_ADDR, frame_done=0, count=0, pending flush cleared.
REQ-031 SHALL drop any in-flight word when reset occurs mid-operation; pixel_ready is 0 while reset_n is low.

Configuration
REQ-032 SHALL compile parity support only when ZBT_PACKER_PARITY_EN is defined.
REQ-033 SHALL, without ZBT_PACKER_PARITY_EN, zero all spare bits.
REQ-034 SHALL, with ZBT_PACKER_PARITY_EN, set spare bit PIX_W*PIX_PER_WORD+k to the even parity of pixel k (0 for unfilled slots); requires PIX_PER_WORD <= spare bit count.

Structure
REQ-035 SHALL put ZBT_WORD_W=36 and the default geometry constants in shared package zbt_pkg.
REQ-036 SHALL use one sub-module, zbt_addr_gen (wrap counter + frame_done), and no others.

Verification
REQ-037 SHALL cover: 8 pixels 0x11..0x88, zbt_ready=1 -> words 0x044332211 @0, 0x088776655 @1.
REQ-038 SHALL cover: zbt_ready=0 for 5 cycles while a word is pending -> data/addr stable, pixel_ready=0, word accepted once.
REQ-039 SHALL cover: 2 pixels 0xAA,0xBB, then flush -> word 0x00000BBAA; flush at count 0 -> no write.
REQ-040 SHALL cover: FRAME_WORDS=3, 4 words -> addresses 0,1,2,0; frame_done pulses once when addr 2 is accepted.
REQ-041 SHALL cover: frame_start after 3 pixels -> partial discarded, next word at BASE_ADDR; reset_n low mid-word -> zbt_we=0 the next cycle.
REQ-042 SHALL cover: with PARITY_EN, pixels 0x01,0x03,0x07,0x00 -> spare bits 4'b0101.
